// File: rtl/ctrl_unit_seq.sv
// Registered ID/EX control decoder: decodes mode/op_code/s, applies the ARM
// condition check, sequences multi-cycle multiplies and honours stall/flush.
module ctrl_unit_seq #(
    parameter int unsigned CMD_W      = 4,
    parameter int unsigned MUL_CYCLES = 3,
    parameter logic [3:0]  MUL_CMD    = 4'b1010
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [3:0]       op_code,
    input  logic             s,
    input  logic [3:0]       cond,
    input  logic [3:0]       flags,
    input  logic             is_mul,
    input  logic             stall_ex,
    input  logic             flush,
    output logic             out_valid,
    output logic [CMD_W-1:0] exec_cmd,
    output logic             mem_read,
    output logic             mem_write,
    output logic             wb_en,
    output logic             b_jump,
    output logic             update_s,
    output logic             busy
);

    localparam logic StIdle    = 1'b0;
    localparam logic StMulWait = 1'b1;

    // Control word layout: {exec_cmd[3:0], update_s, wb_en, mem_read, mem_write, b_jump}
    logic [8:0] ctrl_q, ctrl_d, dec_ctrl;
    logic       state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic       dec_mul, cond_pass, accept;

    logic n_f, z_f, c_f, v_f;
    assign {n_f, z_f, c_f, v_f} = flags;

    always_comb begin
        unique case (cond)
            4'h0:    cond_pass = z_f;
            4'h1:    cond_pass = !z_f;
            4'h2:    cond_pass = c_f;
            4'h3:    cond_pass = !c_f;
            4'h4:    cond_pass = n_f;
            4'h5:    cond_pass = !n_f;
            4'h6:    cond_pass = v_f;
            4'h7:    cond_pass = !v_f;
            4'h8:    cond_pass = c_f && !z_f;
            4'h9:    cond_pass = !c_f || z_f;
            4'hA:    cond_pass = (n_f == v_f);
            4'hB:    cond_pass = (n_f != v_f);
            4'hC:    cond_pass = !z_f && (n_f == v_f);
            4'hD:    cond_pass = z_f || (n_f != v_f);
            4'hE:    cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    always_comb begin
        dec_ctrl = '0;
        dec_mul  = 1'b0;
        unique case (mode)
            2'b00: begin
                if (is_mul) begin
                    dec_mul  = 1'b1;
                    dec_ctrl = {MUL_CMD, s, 1'b1, 3'b000};
                end else begin
                    unique case (op_code)
                        4'b1101: dec_ctrl = {4'b0001, s, 1'b1, 3'b000};
                        4'b1111: dec_ctrl = {4'b1001, s, 1'b1, 3'b000};
                        4'b0100: dec_ctrl = {4'b0010, s, 1'b1, 3'b000};
                        4'b0101: dec_ctrl = {4'b0011, s, 1'b1, 3'b000};
                        4'b0010: dec_ctrl = {4'b0100, s, 1'b1, 3'b000};
                        4'b0110: dec_ctrl = {4'b0101, s, 1'b1, 3'b000};
                        4'b0000: dec_ctrl = {4'b0110, s, 1'b1, 3'b000};
                        4'b1100: dec_ctrl = {4'b0111, s, 1'b1, 3'b000};
                        4'b0001: dec_ctrl = {4'b1000, s, 1'b1, 3'b000};
                        4'b1010: dec_ctrl = {4'b0100, 1'b1, 1'b0, 3'b000};
                        4'b1000: dec_ctrl = {4'b0110, 1'b1, 1'b0, 3'b000};
                        default: dec_ctrl = '0;
                    endcase
                end
            end
            2'b01:   dec_ctrl = s ? {4'b0010, 1'b0, 1'b1, 3'b100}
                                  : {4'b0010, 1'b0, 1'b0, 3'b010};
            2'b10:   dec_ctrl = {4'b0000, 1'b0, 1'b0, 3'b001};
            default: dec_ctrl = '0;
        endcase
    end

    assign in_ready = !rst && (state_q == StIdle) && !flush && (!valid_q || !stall_ex);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        ctrl_d  = ctrl_q;
        if (flush) begin
            state_d = StIdle;
            cnt_d   = '0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            ctrl_d  = '0;
        end else if (state_q == StMulWait) begin
            // The multiply counter keeps running even while EX stalls.
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        end else if (accept) begin
            ctrl_d = cond_pass ? dec_ctrl : '0;
            if (cond_pass && dec_mul && (MUL_CYCLES > 1)) begin
                valid_d = 1'b0;
                busy_d  = 1'b1;
                cnt_d   = 4'(MUL_CYCLES - 1);
                state_d = StMulWait;
            end else begin
                valid_d = 1'b1;
            end
        end else if (!stall_ex) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign exec_cmd  = CMD_W'(ctrl_q[8:5]);
    assign update_s  = ctrl_q[4];
    assign wb_en     = ctrl_q[3];
    assign mem_read  = ctrl_q[2];
    assign mem_write = ctrl_q[1];
    assign b_jump    = ctrl_q[0];

endmodule

// File: tb/tb_ctrl_unit_seq.sv
// Directed plus randomized bench for ctrl_unit_seq against a cycle-level
// behavioural model of the accept / multiply / stall / flush rules.
module tb_ctrl_unit_seq;

    localparam int unsigned MulCycles = 3;

    logic       clk = 1'b0;
    logic       rst, in_valid, s, is_mul, stall_ex, flush;
    logic [1:0] mode;
    logic [3:0] op_code, cond, flags;
    logic       in_ready, out_valid, mem_read, mem_write, wb_en, b_jump, update_s, busy;
    logic [3:0] exec_cmd;

    ctrl_unit_seq #(.CMD_W(4), .MUL_CYCLES(MulCycles), .MUL_CMD(4'b1010)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .op_code(op_code), .s(s), .cond(cond), .flags(flags),
        .is_mul(is_mul), .stall_ex(stall_ex), .flush(flush),
        .out_valid(out_valid), .exec_cmd(exec_cmd), .mem_read(mem_read),
        .mem_write(mem_write), .wb_en(wb_en), .b_jump(b_jump),
        .update_s(update_s), .busy(busy)
    );

    always #5 clk = !clk;

    int checks   = 0;
    int failures = 0;

    // Model state: expected out_valid, cycles left before a multiply retires,
    // expected control word and whether that word is defined right now.
    logic       m_valid = 1'b0;
    int         m_rem   = 0;
    logic [8:0] m_ctrl  = '0;
    logic       m_known = 1'b0;

    wire [8:0] dut_ctrl = {exec_cmd, update_s, wb_en, mem_read, mem_write, b_jump};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;            4'h1: return !z;
            4'h2: return cy;           4'h3: return !cy;
            4'h4: return n;            4'h5: return !n;
            4'h6: return v;            4'h7: return !v;
            4'h8: return cy && !z;     4'h9: return !cy || z;
            4'hA: return n == v;       4'hB: return n != v;
            4'hC: return !z && n == v; 4'hD: return z || n != v;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [8:0] decode(input logic [1:0] md, input logic [3:0] op,
                                          input logic sb, input logic mul);
        logic [3:0] cmd;
        if (md == 2'b01) return sb ? 9'b0010_0_1_100 : 9'b0010_0_0_010;
        if (md == 2'b10) return 9'b0000_0_0_001;
        if (md == 2'b11) return 9'b0;
        if (mul) return {4'b1010, sb, 1'b1, 3'b000};
        if (op == 4'b1010) return 9'b0100_1_0_000;
        if (op == 4'b1000) return 9'b0110_1_0_000;
        case (op)
            4'b1101: cmd = 4'b0001;  4'b1111: cmd = 4'b1001;
            4'b0100: cmd = 4'b0010;  4'b0101: cmd = 4'b0011;
            4'b0010: cmd = 4'b0100;  4'b0110: cmd = 4'b0101;
            4'b0000: cmd = 4'b0110;  4'b1100: cmd = 4'b0111;
            4'b0001: cmd = 4'b1000;
            default: return 9'b0;
        endcase
        return {cmd, sb, 1'b1, 3'b000};
    endfunction

    function automatic logic model_ready();
        if (rst || flush || m_rem > 0) return 1'b0;
        return !m_valid || !stall_ex;
    endfunction

    // One clock: check in_ready mid-cycle, advance the model, check outputs after the edge.
    task automatic cycle(input string tag);
        logic acc, pass, mul;
        #1;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(model_ready()));
        acc  = in_valid && model_ready();
        pass = cond_ok(cond, flags);
        mul  = (mode == 2'b00) && is_mul;
        @(posedge clk);
        if (rst || flush) begin
            m_valid = 1'b0; m_rem = 0; m_ctrl = '0; m_known = 1'b1;
        end else if (m_rem > 0) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) m_valid = 1'b1;
        end else if (acc) begin
            m_ctrl  = pass ? decode(mode, op_code, s, is_mul) : 9'b0;
            m_known = 1'b1;
            if (pass && mul && MulCycles > 1) begin
                m_valid = 1'b0;
                m_rem   = MulCycles - 1;
            end else begin
                m_valid = 1'b1;
            end
        end else if (!stall_ex) begin
            m_valid = 1'b0;
            m_known = 1'b0;
        end
        #1;
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, ".busy"}, 32'(busy), 32'(m_rem > 0));
        if (m_known) chk({tag, ".ctrl"}, 32'(dut_ctrl), 32'(m_ctrl));
    endtask

    task automatic instr(input logic [1:0] md, input logic [3:0] op, input logic sb,
                         input logic [3:0] c, input logic mul);
        in_valid = 1'b1; mode = md; op_code = op; s = sb; cond = c; is_mul = mul;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; mode = '0; op_code = 4'b0100; s = 1'b1;
        cond = 4'hE; flags = '0; is_mul = 1'b0; stall_ex = 1'b0; flush = 1'b0;

        // Reset held two cycles with in_valid high.
        cycle("rst0");
        cycle("rst1");
        chk("rst.ctrl_zero", 32'(dut_ctrl), 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst.ready_after", 32'(in_ready), 32'd1);

        // Back-to-back stream of single-cycle instructions.
        instr(2'b00, 4'b0100, 1'b1, 4'hE, 1'b0); cycle("add");
        chk("add.lit", 32'(dut_ctrl), 32'(9'b0010_1_1_000));
        instr(2'b00, 4'b1010, 1'b0, 4'hE, 1'b0); cycle("cmp");
        chk("cmp.lit", 32'(dut_ctrl), 32'(9'b0100_1_0_000));
        instr(2'b01, 4'b0000, 1'b1, 4'hE, 1'b0); cycle("ldr");
        chk("ldr.lit", 32'(dut_ctrl), 32'(9'b0010_0_1_100));
        instr(2'b01, 4'b0000, 1'b0, 4'hE, 1'b0); cycle("str");
        chk("str.lit", 32'(dut_ctrl), 32'(9'b0010_0_0_010));
        instr(2'b10, 4'b0000, 1'b0, 4'hE, 1'b0); cycle("b");
        chk("b.lit", 32'(dut_ctrl), 32'(9'b0000_0_0_001));

        // Condition check with Z set.
        flags = 4'b0100;
        instr(2'b00, 4'b1101, 1'b0, 4'h1, 1'b0); cycle("mov_ne");
        chk("mov_ne.lit", 32'({out_valid, dut_ctrl}), 32'({1'b1, 9'b0}));
        instr(2'b00, 4'b1101, 1'b0, 4'h0, 1'b0); cycle("mov_eq");
        chk("mov_eq.lit", 32'(dut_ctrl), 32'(9'b0001_0_1_000));

        // Multiply: two busy cycles then output, next instruction accepted then.
        instr(2'b00, 4'b0000, 1'b0, 4'hE, 1'b1); cycle("mul_acc");
        chk("mul.busy", 32'({busy, out_valid}), 32'(2'b10));
        instr(2'b00, 4'b0100, 1'b0, 4'hE, 1'b0);
        cycle("mul_w1");
        cycle("mul_w2");
        chk("mul.lit", 32'({out_valid, dut_ctrl}), 32'({1'b1, 9'b1010_0_1_000}));
        cycle("mul_next");

        // Stall after a SUB output with the next instruction waiting.
        instr(2'b00, 4'b0010, 1'b0, 4'hE, 1'b0); cycle("sub");
        instr(2'b00, 4'b0001, 1'b0, 4'hE, 1'b0); stall_ex = 1'b1;
        for (int i = 0; i < 4; i++) cycle("stall");
        chk("stall.hold", 32'({out_valid, dut_ctrl}), 32'({1'b1, 9'b0100_0_1_000}));
        stall_ex = 1'b0; cycle("stall_rel");
        chk("stall_rel.lit", 32'(dut_ctrl), 32'(9'b1000_0_1_000));

        // Flush during multiply wait, with an instruction presented alongside.
        instr(2'b00, 4'b0000, 1'b1, 4'hE, 1'b1); cycle("fl_mul");
        instr(2'b00, 4'b0100, 1'b1, 4'hE, 1'b0); flush = 1'b1; cycle("flush1");
        flush = 1'b0; in_valid = 1'b0; cycle("flush_idle");
        // Flush coincident with in_valid while idle.
        instr(2'b00, 4'b1101, 1'b1, 4'hE, 1'b0); flush = 1'b1; cycle("flush2");
        chk("flush2.out", 32'({out_valid, busy, dut_ctrl}), 32'd0);
        flush = 1'b0; in_valid = 1'b0; cycle("flush_after");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 99) == 0);
            flush    = ($urandom_range(0, 19) == 0);
            stall_ex = ($urandom_range(0, 2) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            mode     = 2'($urandom_range(0, 3));
            op_code  = 4'($urandom_range(0, 15));
            s        = 1'($urandom_range(0, 1));
            cond     = ($urandom_range(0, 1) == 0) ? 4'hE : 4'($urandom_range(0, 15));
            flags    = 4'($urandom_range(0, 15));
            is_mul   = ($urandom_range(0, 3) == 0);
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
